bit_serial_collect_reg: RTL and testbench

- Bit-serial to parallel collector: the write-back counterpart of the bit-serial shift register file.
- Each cycle it accepts one bit per lane, MSB first, for VEC_LENGTH lanes.
- After DATA_WIDTH accepted bits it presents the reassembled parallel words with a valid/ready handshake.
- Sits between bit-serial PE outputs and the on-chip SRAM write port.

---
 rtl/bit_serial_collect_reg.sv | 118 +++++++++++
 tb/tb_bit_serial_collect_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_collect_reg.sv
// Bit-serial to parallel collector: shifts one bit per lane (MSB first) and presents
// reassembled words with valid/ready. Define BIT_SERIAL_COLLECT_DBUF_EN for double buffering.
module bit_serial_collect_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [VEC_LENGTH-1:0]                  d_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   clear,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  d_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(DATA_WIDTH)-1:0]          bit_cnt
);

  localparam int              CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                                 r_state;
  state_t                                 w_state_next;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-2:0]  r_sreg;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  w_shifted;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  r_d_out;
  logic [CW-1:0]                          r_bit_cnt;
  logic                                   w_accept;
  logic                                   w_final;
  logic                                   w_pop;

  assign d_out   = r_d_out;
  assign bit_cnt = r_bit_cnt;

  // A slice coinciding with clear is dropped, so clear gates the accept.
  assign w_accept = in_valid & in_ready & ~clear;
  assign w_final  = w_accept & (r_bit_cnt == LAST);
  assign w_pop    = out_valid & out_ready;

  // Per-lane shift of the stored bits with the incoming bit appended as LSB
  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_shifted[j] = {r_sreg[j], d_in[j]};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_COLLECT;
    end else begin
      case (r_state)
        S_COLLECT: w_state_next = w_final ? S_HOLD : S_COLLECT;
        S_HOLD:    w_state_next = (w_pop && !w_final) ? S_COLLECT : S_HOLD;
        default:   w_state_next = S_COLLECT;
      endcase
    end
  end

  // FSM outputs: only registered state, bit count and out_ready feed the handshake
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    case (r_state)
      S_COLLECT: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
      S_HOLD: begin
        out_valid = 1'b1;
`ifdef BIT_SERIAL_COLLECT_DBUF_EN
        in_ready  = !(!out_ready && (r_bit_cnt == LAST));
`else
        in_ready  = 1'b0;
`endif
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
    endcase
  end

  // Shift registers, bit counter and output word register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_d_out   <= '0;
    end else if (clear) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      for (int j = 0; j < VEC_LENGTH; j++) begin
        r_sreg[j] <= w_shifted[j][DATA_WIDTH-2:0];
      end
      if (w_final) begin
        r_bit_cnt <= '0;
        r_d_out   <= w_shifted;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_collect_reg.sv
// Directed self-checking bench for bit_serial_collect_reg (DATA_WIDTH=8, VEC_LENGTH=2);
// expectations follow BIT_SERIAL_COLLECT_DBUF_EN when it is defined.
module tb_bit_serial_collect_reg;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      d_in;
  logic            in_valid;
  logic            in_ready;
  logic            clear;
  logic [1:0][7:0] d_out;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      bit_cnt;

  int              n_vec = 0;
  int              n_err = 0;
  logic [15:0]     exp_d = 16'h0000;
  int              cyc;

  bit_serial_collect_reg #(.DATA_WIDTH(8), .VEC_LENGTH(2)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .d_out(d_out), .out_valid(out_valid), .out_ready(out_ready),
    .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams lane0=a, lane1=b MSB first; gaps[c]=1 idles cycle c (1-based).
  task automatic send_word(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] gaps, output int cycles);
    int bi;
    int acc;
    bi = 7;
    acc = 0;
    cycles = 0;
    while (bi >= 0 && cycles < 16) begin
      cycles++;
      if (gaps[cycles] === 1'b1) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        d_in = {b[bi], a[bi]};
      end
      tick();
      if (gaps[cycles] !== 1'b1) begin
        bi--;
        acc++;
      end
      if (bi >= 0) begin
        check_eq("snd_cnt", {29'd0, bit_cnt}, acc);
        check_eq("snd_ov", {31'd0, out_valid}, 32'd0);
        check_eq("snd_hold", {16'd0, d_out}, {16'd0, exp_d});
      end
    end
    in_valid = 1'b0;
  endtask

  logic [7:0] wl0 [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] wl1 [3] = '{8'hEE, 8'hDD, 8'hCC};

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; d_in = 2'b00; out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_irdy", {31'd0, in_ready}, 32'd1);
    check_eq("rst_ov", {31'd0, out_valid}, 32'd0);
    check_eq("rst_cnt", {29'd0, bit_cnt}, 32'd0);
    check_eq("rst_dout", {16'd0, d_out}, 32'd0);

    // Plain word, consumer always ready
    send_word(8'hA5, 8'h3C, 16'h0000, cyc);
    check_eq("w1_cyc", cyc, 32'd8);
    check_eq("w1_ov", {31'd0, out_valid}, 32'd1);
    check_eq("w1_dout", {16'd0, d_out}, 32'h3CA5);
    check_eq("w1_cnt", {29'd0, bit_cnt}, 32'd0);
`ifdef BIT_SERIAL_COLLECT_DBUF_EN
    check_eq("w1_irdy", {31'd0, in_ready}, 32'd1);
`else
    check_eq("w1_irdy", {31'd0, in_ready}, 32'd0);
`endif
    exp_d = 16'h3CA5;
    tick();
    check_eq("w1_pulse", {31'd0, out_valid}, 32'd0);

    // Same word with idle cycles 3 and 6
    send_word(8'hA5, 8'h3C, 16'h0048, cyc);
    check_eq("gap_cyc", cyc, 32'd10);
    check_eq("gap_ov", {31'd0, out_valid}, 32'd1);
    check_eq("gap_dout", {16'd0, d_out}, 32'h3CA5);
    tick();
    check_eq("gap_pulse", {31'd0, out_valid}, 32'd0);

    // Backpressure after completion
    out_ready = 1'b0;
    send_word(8'h96, 8'h69, 16'h0000, cyc);
    check_eq("bp_ov", {31'd0, out_valid}, 32'd1);
    check_eq("bp_dout", {16'd0, d_out}, 32'h6996);
    exp_d = 16'h6996;
`ifdef BIT_SERIAL_COLLECT_DBUF_EN
    for (int i = 7; i >= 1; i--) begin
      in_valid = 1'b1;
      d_in = {wl1[0][i], wl0[0][i]};
      check_eq("bp_irdy_on", {31'd0, in_ready}, 32'd1);
      tick();
      check_eq("bp_cnt", {29'd0, bit_cnt}, 8 - i);
      check_eq("bp_ov_hold", {31'd0, out_valid}, 32'd1);
      check_eq("bp_dout_hold", {16'd0, d_out}, {16'd0, exp_d});
    end
    d_in = {wl1[0][0], wl0[0][0]};
    for (int k = 0; k < 2; k++) begin
      check_eq("bp_stall", {31'd0, in_ready}, 32'd0);
      tick();
      check_eq("bp_cnt7", {29'd0, bit_cnt}, 32'd7);
      check_eq("bp_ov_stall", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    check_eq("bp_irdy_pop", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("reload_ov", {31'd0, out_valid}, 32'd1);
    check_eq("reload_dout", {16'd0, d_out}, {16'd0, wl1[0], wl0[0]});
    check_eq("reload_cnt", {29'd0, bit_cnt}, 32'd0);
    exp_d = {wl1[0], wl0[0]};
    in_valid = 1'b0;
    tick();
    check_eq("reload_pop", {31'd0, out_valid}, 32'd0);
`else
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      d_in = 2'b11;
      check_eq("bp_irdy_off", {31'd0, in_ready}, 32'd0);
      tick();
      check_eq("bp_ov_hold", {31'd0, out_valid}, 32'd1);
      check_eq("bp_dout_hold", {16'd0, d_out}, {16'd0, exp_d});
      check_eq("bp_cnt", {29'd0, bit_cnt}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_pop_ov", {31'd0, out_valid}, 32'd0);
    check_eq("bp_pop_dout", {16'd0, d_out}, {16'd0, exp_d});
`endif

    // Abort a partial word of ones, then collect a fresh word
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      d_in = 2'b11;
      tick();
    end
    check_eq("clr_pre_cnt", {29'd0, bit_cnt}, 32'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check_eq("clr_cnt", {29'd0, bit_cnt}, 32'd0);
    check_eq("clr_ov", {31'd0, out_valid}, 32'd0);
    check_eq("clr_dout", {16'd0, d_out}, {16'd0, exp_d});
    send_word(8'h81, 8'h7E, 16'h0000, cyc);
    check_eq("clr_new_ov", {31'd0, out_valid}, 32'd1);
    check_eq("clr_new_dout", {16'd0, d_out}, 32'h7E81);
    exp_d = 16'h7E81;
    tick();

    // Reset while holding a word
    out_ready = 1'b0;
    send_word(8'h5A, 8'h5A, 16'h0000, cyc);
    check_eq("rh_ov", {31'd0, out_valid}, 32'd1);
    check_eq("rh_dout", {16'd0, d_out}, 32'h5A5A);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rh_ov0", {31'd0, out_valid}, 32'd0);
    check_eq("rh_dout0", {16'd0, d_out}, 32'd0);
    check_eq("rh_cnt0", {29'd0, bit_cnt}, 32'd0);
    check_eq("rh_irdy", {31'd0, in_ready}, 32'd1);
    exp_d = 16'h0000;
    out_ready = 1'b1;

`ifdef BIT_SERIAL_COLLECT_DBUF_EN
    // Back-to-back words at full rate
    for (int k = 1; k <= 24; k++) begin
      in_valid = 1'b1;
      d_in = {wl1[(k-1)/8][7-((k-1)%8)], wl0[(k-1)/8][7-((k-1)%8)]};
      check_eq("b2b_irdy", {31'd0, in_ready}, 32'd1);
      tick();
      check_eq("b2b_ov", {31'd0, out_valid}, (k % 8 == 0) ? 32'd1 : 32'd0);
      if (k % 8 == 0) begin
        check_eq("b2b_dout", {16'd0, d_out}, {16'd0, wl1[(k-1)/8], wl0[(k-1)/8]});
      end
    end
    in_valid = 1'b0;
    tick();
    check_eq("b2b_end", {31'd0, out_valid}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
